// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Shares one single-port data memory between two requesters (A and B).
//   Each access is a fixed three-state sequence: IDLE (grant), ACCESS
//   (memory strobe) and RESP (one-cycle response strobe to the winner).
//   Addresses with any bit set above bit 9 are rejected: no memory strobe
//   is issued and the response carries rerr=1 with rdata=0.
//
// Parameters
//   PRIO_MODE      0 = round-robin on ties, 1 = port A always wins ties
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   a_*/b_*        requester ports: req/we/addr/wdata in,
//                  gnt (combinational), rvalid/rdata/rerr (registered) out
//   mem_*          data-memory side: registered strobes, address and write
//                  data; mem_read_data is a combinational read result
//   busy           high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int PRIO_MODE = 0
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        a_req,
   input  logic        a_we,
   input  logic [63:0] a_addr,
   input  logic [63:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [63:0] a_rdata,
   output logic        a_rerr,

   input  logic        b_req,
   input  logic        b_we,
   input  logic [63:0] b_addr,
   input  logic [63:0] b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [63:0] b_rdata,
   output logic        b_rerr,

   output logic        mem_memwrite,
   output logic        mem_memread,
   output logic [63:0] mem_add,
   output logic [63:0] mem_write_data,
   input  logic [63:0] mem_read_data,

   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   // Arbitration
   logic        grant_a;
   logic        grant_b;
   logic        last_b;     // 1 = B was granted most recently

   // Winner's request, selected combinationally in IDLE
   logic        sel_we;
   logic [63:0] sel_addr;
   logic [63:0] sel_wdata;
   logic        sel_err;

   // Transaction context held from the grant edge to the end of RESP
   logic        lat_b;
   logic        lat_we;
   logic        lat_err;

   // Registered memory-side outputs
   logic        mem_write_q;
   logic        mem_read_q;
   logic [63:0] mem_add_q;
   logic [63:0] mem_wdata_q;

   // Registered per-port responses
   logic        a_rvalid_q;
   logic [63:0] a_rdata_q;
   logic        a_rerr_q;
   logic        b_rvalid_q;
   logic [63:0] b_rdata_q;
   logic        b_rerr_q;

   logic [63:0] rsp_data;

   // --------------------------------------------------------------------------
   // Next-state and grant logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      state_next = state;

      case (state)
         IDLE: begin
            if (a_req && b_req) begin
               // Tie: fixed priority favours A; round-robin favours the port
               // that did not win last time.
               if (PRIO_MODE == 1 || last_b) begin
                  grant_a = 1'b1;
               end else begin
                  grant_b = 1'b1;
               end
            end else begin
               grant_a = a_req;
               grant_b = b_req;
            end
            if (grant_a || grant_b) begin
               state_next = ACCESS;
            end
         end
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Winner's request fields; only meaningful when a grant is issued.
   assign sel_we    = grant_b ? b_we    : a_we;
   assign sel_addr  = grant_b ? b_addr  : a_addr;
   assign sel_wdata = grant_b ? b_wdata : a_wdata;
   assign sel_err   = |sel_addr[63:10];

   // Read data captured at the end of ACCESS; writes and rejected
   // addresses return zero.
   assign rsp_data  = (lat_we || lat_err) ? 64'd0 : mem_read_data;

   // --------------------------------------------------------------------------
   // State, context and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_b      <= 1'b1;  // A wins the first tie after reset
         lat_b       <= 1'b0;
         lat_we      <= 1'b0;
         lat_err     <= 1'b0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_add_q   <= 64'd0;
         mem_wdata_q <= 64'd0;
         a_rvalid_q  <= 1'b0;
         a_rdata_q   <= 64'd0;
         a_rerr_q    <= 1'b0;
         b_rvalid_q  <= 1'b0;
         b_rdata_q   <= 64'd0;
         b_rerr_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples
         // the pre-edge values regardless of statement order.
         state <= state_next;

         case (state)
            IDLE: begin
               if (grant_a || grant_b) begin
                  last_b      <= grant_b;
                  lat_b       <= grant_b;
                  lat_we      <= sel_we;
                  lat_err     <= sel_err;
                  // The memory write is level-sensitive, so its controls
                  // come straight from flops that change only on this edge
                  // and the next one; a rejected address never strobes.
                  mem_write_q <= sel_we & ~sel_err;
                  mem_read_q  <= ~sel_we & ~sel_err;
                  mem_add_q   <= sel_addr;
                  mem_wdata_q <= sel_wdata;
               end
            end

            ACCESS: begin
               mem_write_q <= 1'b0;
               mem_read_q  <= 1'b0;
               mem_add_q   <= 64'd0;
               mem_wdata_q <= 64'd0;
               a_rvalid_q  <= ~lat_b;
               a_rdata_q   <= lat_b ? 64'd0 : rsp_data;
               a_rerr_q    <= ~lat_b & lat_err;
               b_rvalid_q  <= lat_b;
               b_rdata_q   <= lat_b ? rsp_data : 64'd0;
               b_rerr_q    <= lat_b & lat_err;
            end

            RESP: begin
               a_rvalid_q <= 1'b0;
               a_rdata_q  <= 64'd0;
               a_rerr_q   <= 1'b0;
               b_rvalid_q <= 1'b0;
               b_rdata_q  <= 64'd0;
               b_rerr_q   <= 1'b0;
            end

            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   // Grants are combinational from req, so they are also gated by reset to
   // stay low while reset is asserted.
   assign a_gnt          = grant_a & reset;
   assign b_gnt          = grant_b & reset;

   assign a_rvalid       = a_rvalid_q;
   assign a_rdata        = a_rdata_q;
   assign a_rerr         = a_rerr_q;
   assign b_rvalid       = b_rvalid_q;
   assign b_rdata        = b_rdata_q;
   assign b_rerr         = b_rerr_q;

   assign mem_memwrite   = mem_write_q;
   assign mem_memread    = mem_read_q;
   assign mem_add        = mem_add_q;
   assign mem_write_data = mem_wdata_q;

   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Scoreboard bench for data_mem_arbiter. A predictor process decides, from
//   the arbitration rules and a simple "free again at cycle X" timeline,
//   which port must be granted each cycle, checks grants, busy and the
//   memory-side bus, and queues the expected response. A separate monitor
//   pops the queue whenever an rvalid appears and computes the expected
//   data from a plain reference memory array. A second instance with
//   PRIO_MODE=1 is exercised with a short directed run.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   // ---------------------------------------------------------------- signals
   logic        clock;
   logic        reset;

   logic        a_req, a_we, b_req, b_we;
   logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_gnt, a_rvalid, a_rerr, b_gnt, b_rvalid, b_rerr;
   logic [63:0] a_rdata, b_rdata;
   logic        mem_memwrite, mem_memread, busy;
   logic [63:0] mem_add, mem_write_data, mem_read_data;

   // Fixed-priority instance
   logic        p_a_req, p_b_req;
   logic        p_a_gnt, p_a_rvalid, p_a_rerr, p_b_gnt, p_b_rvalid, p_b_rerr;
   logic [63:0] p_a_rdata, p_b_rdata;
   logic        p_mem_memwrite, p_mem_memread, p_busy;
   logic [63:0] p_mem_add, p_mem_write_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // ------------------------------------------------------------------- DUTs
   data_mem_arbiter #(.PRIO_MODE(0)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rerr(a_rerr),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rerr(b_rerr),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_add(mem_add), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .busy(busy)
   );

   data_mem_arbiter #(.PRIO_MODE(1)) dut_prio (
      .clock(clock), .reset(reset),
      .a_req(p_a_req), .a_we(1'b0), .a_addr(64'd0), .a_wdata(64'd0),
      .a_gnt(p_a_gnt), .a_rvalid(p_a_rvalid), .a_rdata(p_a_rdata), .a_rerr(p_a_rerr),
      .b_req(p_b_req), .b_we(1'b0), .b_addr(64'd0), .b_wdata(64'd0),
      .b_gnt(p_b_gnt), .b_rvalid(p_b_rvalid), .b_rdata(p_b_rdata), .b_rerr(p_b_rerr),
      .mem_memwrite(p_mem_memwrite), .mem_memread(p_mem_memread),
      .mem_add(p_mem_add), .mem_write_data(p_mem_write_data),
      .mem_read_data(64'd0), .busy(p_busy)
   );

   // ------------------------------------------------------------ clock, cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // -------------------------------------------- data memory seen by the DUT
   logic [63:0] dmem    [0:1023];
   logic [63:0] ref_mem [0:1023];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         dmem[i]    = 64'(i);
         ref_mem[i] = 64'(i);
      end
   end

   assign mem_read_data = dmem[mem_add[9:0]];
   always @(posedge clock) if (mem_memwrite) dmem[mem_add[9:0]] <= mem_write_data;

   // ------------------------------------------------------------------ check
   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // -------------------------------------------------------------- predictor
   typedef struct {
      bit          port;   // 0 = A, 1 = B
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          due;    // cycle in which rvalid must appear
   } txn_t;

   txn_t exp_q[$];
   bit   ref_last_b = 1'b1;
   int   next_free  = 0;    // first cycle in which a new grant is possible
   bit   acc_valid  = 1'b0;
   int   acc_cyc    = 0;
   txn_t acc_t;
   bit   win_a, win_b;
   bit   acc_err;
   txn_t new_t;

   always @(negedge clock) begin
      if (!reset) begin
         check("reset_ctl", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rerr, b_rerr,
                             mem_memwrite, mem_memread, busy}, 0);
         check("reset_rdata", {a_rdata, b_rdata}, 0);
         check("reset_membus", {mem_add, mem_write_data}, 0);
         exp_q.delete();
         ref_last_b = 1'b1;
         next_free  = 0;
         acc_valid  = 1'b0;
      end else begin
         win_a = 1'b0;
         win_b = 1'b0;
         if (cyc >= next_free) begin
            if (a_req && b_req) begin
               if (ref_last_b) win_a = 1'b1; else win_b = 1'b1;
            end else if (a_req) begin
               win_a = 1'b1;
            end else if (b_req) begin
               win_b = 1'b1;
            end
         end
         check("gnt", {a_gnt, b_gnt}, {win_a, win_b});
         check("busy", busy, (cyc < next_free));

         if (acc_valid && cyc == acc_cyc) begin
            acc_err = (acc_t.addr[63:10] != 0);
            check("mem_bus", {mem_memwrite, mem_memread, mem_add, mem_write_data},
                  {acc_t.we & ~acc_err, ~acc_t.we & ~acc_err, acc_t.addr, acc_t.wdata});
         end else begin
            check("mem_bus_idle", {mem_memwrite, mem_memread, mem_add, mem_write_data}, 0);
         end

         if (win_a || win_b) begin
            new_t.port  = win_b;
            new_t.we    = win_b ? b_we    : a_we;
            new_t.addr  = win_b ? b_addr  : a_addr;
            new_t.wdata = win_b ? b_wdata : a_wdata;
            new_t.due   = cyc + 2;
            exp_q.push_back(new_t);
            acc_t      = new_t;
            acc_cyc    = cyc + 1;
            acc_valid  = 1'b1;
            next_free  = cyc + 3;
            ref_last_b = win_b;
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   txn_t        mt;
   bit          m_err;
   logic [63:0] m_data;

   always @(negedge clock) begin
      if (reset) begin
         if (a_rvalid || b_rvalid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rvalid", {a_rvalid, b_rvalid}, 0);
            end else begin
               mt     = exp_q.pop_front();
               m_err  = (mt.addr[63:10] != 0);
               m_data = (m_err || mt.we) ? 64'd0 : ref_mem[mt.addr[9:0]];
               if (mt.we && !m_err) ref_mem[mt.addr[9:0]] = mt.wdata;
               check("rsp_cycle", cyc, mt.due);
               check("rsp_port", {a_rvalid, b_rvalid}, mt.port ? 2'b01 : 2'b10);
               if (mt.port) begin
                  check("b_rsp", {b_rdata, b_rerr}, {m_data, m_err});
                  check("a_quiet", {a_rdata, a_rerr}, 0);
               end else begin
                  check("a_rsp", {a_rdata, a_rerr}, {m_data, m_err});
                  check("b_quiet", {b_rdata, b_rerr}, 0);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            errors++;
            checks++;
            $display("FAIL missing_rvalid: got none expected response due cycle %0d (cycle %0d)",
                     exp_q[0].due, cyc);
            void'(exp_q.pop_front());
         end else begin
            check("rsp_idle", {a_rdata, a_rerr, b_rdata, b_rerr}, 0);
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   // Called at posedge+1; returns at posedge+1 right after the grant edge.
   task automatic port_op(input bit port, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata);
      int waited = 0;
      bit got    = 1'b0;
      if (port) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
      end
      while (!got && waited < 200) begin
         @(negedge clock);
         got = port ? b_gnt : a_gnt;
         waited++;
      end
      if (!got) begin
         errors++;
         checks++;
         $display("FAIL grant_timeout: port %0d got no grant expected one within 200 cycles", port);
      end
      @(posedge clock);
      #1;
      if (port) begin
         b_req = 1'b0; b_we = 1'b0; b_addr = 64'd0; b_wdata = 64'd0;
      end else begin
         a_req = 1'b0; a_we = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic random_port(input bit port, input int n);
      logic [63:0] addr;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) addr = {$urandom, $urandom} | 64'h400;
         else                           addr = 64'($urandom_range(0, 31));
         port_op(port, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
         idle($urandom_range(0, 3));
      end
   endtask

   // -------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // -------------------------------------------------------------- stimulus
   int na, nb;
   bit got_b;

   initial begin
      reset = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
      b_req = 1'b0; b_we = 1'b0; b_addr = 64'd0; b_wdata = 64'd0;
      p_a_req = 1'b0; p_b_req = 1'b0;
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      idle(1);

      // A reads mem[5]
      port_op(0, 1'b0, 64'd5, 64'd0);
      idle(4);

      // B writes 0xDEAD to 7, then reads it back (second request waits)
      port_op(1, 1'b1, 64'd7, 64'hDEAD);
      port_op(1, 1'b0, 64'd7, 64'd0);
      idle(4);
      check("mem7_written", dmem[7], 64'hDEAD);

      // Both request continuously: round-robin alternation
      fork
         for (int i = 0; i < 4; i++) port_op(0, 1'b0, 64'(i), 64'd0);
         for (int i = 0; i < 4; i++) port_op(1, 1'b0, 64'(i + 16), 64'd0);
      join
      idle(4);

      // Out-of-range read
      port_op(0, 1'b0, 64'h400, 64'd0);
      idle(4);

      // B arrives during A's ACCESS and must be served next
      fork
         port_op(0, 1'b1, 64'd9, 64'h99);
         begin
            idle(1);
            port_op(1, 1'b0, 64'd9, 64'd0);
         end
      join
      idle(4);

      // Reset during the ACCESS of a write to 3
      a_req = 1'b1; a_we = 1'b1; a_addr = 64'd3; a_wdata = 64'h3333;
      @(posedge clock);
      #1;
      a_req = 1'b0; a_we = 1'b0; a_addr = 64'd0; a_wdata = 64'd0;
      #2 reset = 1'b0;
      #1;
      check("rst_access_ctl", {mem_memwrite, mem_memread, busy, a_rvalid}, 0);
      check("rst_access_bus", {mem_add, mem_write_data}, 0);
      repeat (2) @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      idle(4);
      check("mem3_kept", dmem[3], 64'd3);

      // Fixed-priority instance: A wins every slot while it requests
      p_a_req = 1'b1; p_b_req = 1'b1;
      na = 0; nb = 0;
      repeat (30) begin
         @(negedge clock);
         na += int'(p_a_gnt);
         nb += int'(p_b_gnt);
      end
      @(posedge clock);
      #1 p_a_req = 1'b0;
      got_b = 1'b0;
      for (int i = 0; i < 6 && !got_b; i++) begin
         @(negedge clock);
         got_b = p_b_gnt;
      end
      @(posedge clock);
      #1 p_b_req = 1'b0;
      check("prio_a_grants", na, 10);
      check("prio_b_grants", nb, 0);
      check("prio_b_after_a", got_b, 1);
      idle(4);

      // Randomized concurrent traffic
      fork
         random_port(0, 30);
         random_port(1, 30);
      join
      idle(10);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_MODE, default 0, selecting 0 = round-robin or 1 = fixed priority to port A.
REQ-002 The block SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have ports a_req/b_req, input, 1 bit each: access request, held high until granted.
REQ-005 The block SHALL have ports a_we/b_we, input, 1 bit each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports a_addr/b_addr, input, 64 bits each: word address.
REQ-007 The block SHALL have ports a_wdata/b_wdata, input, 64 bits each: write data.
REQ-008 The block SHALL have ports a_gnt/b_gnt, output, 1 bit each: request accepted this cycle.
REQ-009 The block SHALL have ports a_rvalid/b_rvalid, output, 1 bit each: one-cycle response strobe.
REQ-010 The block SHALL have ports a_rdata/b_rdata, output, 64 bits each: read result, valid with rvalid.
REQ-011 The block SHALL have ports a_rerr/b_rerr, output, 1 bit each: out-of-range error, valid with rvalid.
REQ-012 The block SHALL have ports mem_memwrite/mem_memread, output, 1 bit each: data-memory strobes.
REQ-013 The block SHALL have ports mem_add/mem_write_data, output, 64 bits each: data-memory address and data.
REQ-014 The block SHALL have port mem_read_data, input, 64 bits: data-memory read result (combinational).
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; IDLE->ACCESS on any grant, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 a_gnt/b_gnt SHALL be combinational, asserted only in IDLE, at most one at a time, and only for a requesting port.
REQ-018 Arbitration in IDLE: a single requester SHALL win; when both request, PRIO_MODE=1 SHALL select A, PRIO_MODE=0 SHALL select the port not granted last.
REQ-019 On the grant edge, the block SHALL latch the winner's id, we, addr and wdata; after that edge it SHALL ignore requester inputs until the return to IDLE.
REQ-020 In ACCESS, mem_add and mem_write_data SHALL equal the latched values, and exactly one of mem_memwrite/mem_memread SHALL be 1, per the latched we.
REQ-021 Outside ACCESS, mem_memwrite, mem_memread, mem_add and mem_write_data SHALL be 0 and glitch-free (the memory write is level-sensitive).
REQ-022 Range check: the latched addr[63:10] != 0 SHALL suppress both memory strobes in ACCESS and set rerr=1 in RESP.
REQ-023 At the end of ACCESS, the block SHALL register mem_read_data for reads; writes and errors SHALL register 0.
REQ-024 In RESP, the block SHALL assert rvalid, rdata and rerr for the latched port only; the other port's outputs SHALL be 0.
REQ-025 Latency SHALL be: grant in cycle N, memory access in N+1, rvalid in N+2, next grant possible in N+3.
REQ-026 A request arriving while busy SHALL wait, never be dropped, and be arbitrated at the next IDLE.
REQ-027 Round-robin history SHALL update only on a grant, whether or not the other port was requesting.

Reset
REQ-028 While reset=0, the block SHALL immediately force state to IDLE and all outputs to 0, including mem strobes and gnt.
REQ-029 Reset SHALL set round-robin history to "last = B", so port A wins the first tie.
REQ-030 An access in flight at reset assertion SHALL be abandoned with no rvalid, and no write SHALL occur once reset is low.
REQ-031 After reset deasserts, the block SHALL start arbitration at the first rising edge with state IDLE.

Verification
REQ-032 A read only, addr=5, memory preloaded so mem[5]=5 -> a_gnt cycle 0, mem_memread=1 cycle 1, a_rvalid=1 with a_rdata=5 and a_rerr=0 in cycle 2.
REQ-033 B writes addr=7 data=0xDEAD, then B reads addr=7 -> mem_memwrite=1 for exactly one cycle, then b_rdata=0xDEAD.
REQ-034 PRIO_MODE=0, A and B both request continuously -> grants alternate A,B,A,B every 3 cycles; with PRIO_MODE=1 -> A only while A requests.
REQ-035 A reads addr=0x400 -> no mem strobe in ACCESS, a_rvalid=1 with a_rerr=1 and a_rdata=0.
REQ-036 reset=0 asserted during ACCESS of a write to addr=3 -> strobes drop immediately, mem[3] unchanged, no rvalid, busy=0.
REQ-037 B requests during A's ACCESS -> b_gnt in the first IDLE cycle after A's RESP, and B's request is not lost.
